// File: rtl/foobar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : foobar_pkg
//  Description : Shared defaults and types for the multi-divisor counter:
//                channel count, widths, default divisor table and the
//                snapshot handshake state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package foobar_pkg;

    localparam int c_def_num_ch  = 4;
    localparam int c_def_tally_w = 8;
    localparam int c_def_step_w  = 8;
    localparam int c_div_w       = 8;
    localparam int c_max_div     = 255;

    // Default divisor table, ch0 in the least-significant byte.
    localparam logic [c_def_num_ch*c_div_w-1:0] c_def_divisors =
        {8'd7, 8'd5, 8'd3, 8'd2};

    typedef enum logic [0:0] {
        SNAP_IDLE = 1'b0,
        SNAP_HELD = 1'b1
    } snap_state_t;

endpackage : foobar_pkg
`default_nettype wire

// File: rtl/div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : div_chan
//  Description : One divisor channel. Keeps a phase counter modulo DIV,
//                flags a hit when the phase is zero and tallies the hits
//                taken on enabled cycles, with sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_chan
    import foobar_pkg::*;
#(
    parameter int DIV      = 2,
    parameter int TALLY_W  = 8,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    output logic               hit,
    output logic [TALLY_W-1:0] tally,
    output logic               ovf
);

    localparam logic [c_div_w-1:0] c_last    = c_div_w'(DIV - 1);
    localparam logic [c_div_w-1:0] c_ph_one  = c_div_w'(1);
    localparam logic [TALLY_W-1:0] c_tmax    = '1;
    localparam logic [TALLY_W-1:0] c_t_one   = TALLY_W'(1);

    logic [c_div_w-1:0] r_phase;
    logic [TALLY_W-1:0] r_tally;
    logic               r_ovf;
    logic               w_hit;

    // A phase of zero means the enabled-cycle count is a multiple of DIV.
    assign w_hit = (r_phase == '0);

    // Phase walks 0..DIV-1 on enabled cycles; a DIV of 1 pins it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (clr) begin
            r_phase <= '0;
        end else if (en) begin
            r_phase <= (r_phase == c_last) ? '0 : (r_phase + c_ph_one);
        end
    end

    // Count hits on enabled cycles; at the top the tally holds or wraps and ovf latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tally <= '0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_tally <= '0;
            r_ovf   <= 1'b0;
        end else if (en && w_hit) begin
            if (r_tally == c_tmax) begin
                r_ovf   <= 1'b1;
                r_tally <= (SATURATE != 0) ? c_tmax : '0;
            end else begin
                r_tally <= r_tally + c_t_one;
            end
        end
    end

    assign hit   = w_hit;
    assign tally = r_tally;
    assign ovf   = r_ovf;

endmodule : div_chan
`default_nettype wire

// File: rtl/multi_div_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multi_div_counter
//  Description : Shared step counter feeding NUM_CH divisor channels, with
//                combined hit flag and a valid/ready snapshot of all tallies.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_div_counter
    import foobar_pkg::*;
#(
    parameter int                          NUM_CH   = c_def_num_ch,
    parameter int                          TALLY_W  = c_def_tally_w,
    parameter int                          STEP_W   = c_def_step_w,
    parameter logic [NUM_CH*c_div_w-1:0]   DIVISORS = c_def_divisors,
    parameter int                          SATURATE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        clr,
    output logic [STEP_W-1:0]           step,
    output logic [NUM_CH-1:0]           hit,
    output logic                        all_hit,
    output logic [NUM_CH*TALLY_W-1:0]   tally,
    output logic [NUM_CH-1:0]           ovf,
    input  logic                        snap_req,
    output logic                        snap_valid,
    input  logic                        snap_ready,
    output logic [NUM_CH*TALLY_W-1:0]   snap_data
);

    localparam logic [STEP_W-1:0] c_step_one = STEP_W'(1);

    logic [STEP_W-1:0]         r_step;
    logic [NUM_CH-1:0]         w_hit;
    logic [NUM_CH-1:0]         w_ovf;
    logic [NUM_CH*TALLY_W-1:0] w_tally;
    logic [NUM_CH*TALLY_W-1:0] r_snap_data;
    snap_state_t               r_snap_state;
    snap_state_t               w_snap_next;
    logic                      w_snap_load;

    // Free-running enabled-cycle count; its wrap is independent of channel phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= '0;
        end else if (clr) begin
            r_step <= '0;
        end else if (en) begin
            r_step <= r_step + c_step_one;
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            div_chan #(
                .DIV      (int'(DIVISORS[g*c_div_w +: c_div_w])),
                .TALLY_W  (TALLY_W),
                .SATURATE (SATURATE)
            ) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .clr   (clr),
                .hit   (w_hit[g]),
                .tally (w_tally[g*TALLY_W +: TALLY_W]),
                .ovf   (w_ovf[g])
            );
        end
    endgenerate

    // Snapshot state register; clr deliberately has no effect here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_state <= SNAP_IDLE;
        end else begin
            r_snap_state <= w_snap_next;
        end
    end

    // Accept a request only while empty; release the hold on consumer acceptance.
    always_comb begin
        w_snap_next = r_snap_state;
        w_snap_load = 1'b0;
        case (r_snap_state)
            SNAP_IDLE: begin
                if (snap_req) begin
                    w_snap_load = 1'b1;
                    w_snap_next = SNAP_HELD;
                end
            end
            SNAP_HELD: begin
                if (snap_ready) begin
                    w_snap_next = SNAP_IDLE;
                end
            end
            default: begin
                w_snap_next = SNAP_IDLE;
            end
        endcase
    end

    // Capture the pre-increment (and pre-clear) tallies of the request cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_data <= '0;
        end else if (w_snap_load) begin
            r_snap_data <= w_tally;
        end
    end

    assign step       = r_step;
    assign hit        = w_hit;
    assign all_hit    = &w_hit;
    assign tally      = w_tally;
    assign ovf        = w_ovf;
    assign snap_valid = (r_snap_state == SNAP_HELD);
    assign snap_data  = r_snap_data;

endmodule : multi_div_counter
`default_nettype wire
